// File: rtl/vga_pkg.sv
// Shared types and default timing for the frame-buffer SRAM arbiter.
// Also used by the bench SRAM model.
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        READ,
        WRITE_SETUP,
        WRITE_PULSE,
        WRITE_HOLD
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEF_AWIDTH     = 19;
    localparam int DEF_DWIDTH     = 8;
    localparam int DEF_RDCYCLES   = 2;
    localparam int DEF_WRCYCLES   = 2;
    localparam int DEF_TURNCYCLES = 1;
    localparam int DEF_WRSTARVE   = 4;

    // Counter preload for a phase lasting the given number of cycles.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/vmem_phase_cnt.sv
// Loadable 4-bit down-counter with zero flag.
// Times the TURN, READ and WRITE_PULSE phases.
module vmem_phase_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vmem_arb.sv
// Read/write arbiter and strobe sequencer for the asynchronous
// frame-buffer SRAM; reads have priority, bounded by a starvation limit.
module vmem_arb
    import vga_pkg::*;
#(
    parameter int AWIDTH     = DEF_AWIDTH,
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int RDCYCLES   = DEF_RDCYCLES,
    parameter int WRCYCLES   = DEF_WRCYCLES,
    parameter int TURNCYCLES = DEF_TURNCYCLES,
    parameter int WRSTARVE   = DEF_WRSTARVE
) (
    input  logic              MemClk,
    input  logic              ResetN,
    input  logic              RdReq,
    input  logic [AWIDTH-1:0] RdAddr,
    output logic              RdAck,
    output logic [DWIDTH-1:0] RdData,
    output logic              RdDataValid,
    input  logic              WrReq,
    input  logic [AWIDTH-1:0] WrAddr,
    input  logic [DWIDTH-1:0] WrData,
    output logic              WrAck,
    output logic [AWIDTH-1:0] MemAddr,
    output logic [DWIDTH-1:0] MemDataOut,
    output logic              MemDataOe,
    input  logic [DWIDTH-1:0] MemDataIn,
    output logic              MemWE,
    output logic              MemOE,
    output logic              Busy
);

    state_t     state, state_nx;
    op_t        last_op, last_op_nx;
    op_t        pend_op, pend_op_nx;
    op_t        g_op;
    logic       rest, rest_nx;
    logic [3:0] sc;
    logic       rd_grant, wr_grant;
    logic       cnt_load, cnt_zero;
    logic [3:0] cnt_val;
    logic       rd_last;

    vmem_phase_cnt u_phase (
        .clk      (MemClk),
        .rst_n    (ResetN),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // rest blocks granting for one IDLE cycle after each access and
    // for the first cycle out of reset.
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (state == IDLE && !rest) begin
            if (sc >= 4'(WRSTARVE) && WrReq) begin
                wr_grant = 1'b1;
            end else if (RdReq) begin
                rd_grant = 1'b1;
            end else if (WrReq) begin
                wr_grant = 1'b1;
            end
        end
    end

    assign g_op    = wr_grant ? OP_WRITE : OP_READ;
    assign RdAck   = rd_grant;
    assign WrAck   = wr_grant;
    assign Busy    = (state != IDLE);
    assign rd_last = (state == READ) && cnt_zero;

    always_comb begin
        state_nx   = state;
        last_op_nx = last_op;
        pend_op_nx = pend_op;
        rest_nx    = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        unique case (state)
            IDLE: begin
                if (rd_grant || wr_grant) begin
                    pend_op_nx = g_op;
                    if (g_op != last_op && TURNCYCLES > 0) begin
                        state_nx = TURN;
                        cnt_load = 1'b1;
                        cnt_val  = phase_load(TURNCYCLES);
                    end else if (wr_grant) begin
                        state_nx = WRITE_SETUP;
                    end else begin
                        state_nx = READ;
                        cnt_load = 1'b1;
                        cnt_val  = phase_load(RDCYCLES);
                    end
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    if (pend_op == OP_WRITE) begin
                        state_nx = WRITE_SETUP;
                    end else begin
                        state_nx = READ;
                        cnt_load = 1'b1;
                        cnt_val  = phase_load(RDCYCLES);
                    end
                end
            end
            READ: begin
                if (cnt_zero) begin
                    state_nx   = IDLE;
                    last_op_nx = OP_READ;
                    rest_nx    = 1'b1;
                end
            end
            WRITE_SETUP: begin
                state_nx = WRITE_PULSE;
                cnt_load = 1'b1;
                cnt_val  = phase_load(WRCYCLES);
            end
            WRITE_PULSE: begin
                if (cnt_zero) begin
                    state_nx = WRITE_HOLD;
                end
            end
            WRITE_HOLD: begin
                state_nx   = IDLE;
                last_op_nx = OP_WRITE;
                rest_nx    = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge MemClk or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            last_op <= OP_READ;
            pend_op <= OP_READ;
            rest    <= 1'b1;
        end else begin
            state   <= state_nx;
            last_op <= last_op_nx;
            pend_op <= pend_op_nx;
            rest    <= rest_nx;
        end
    end

    // Strobes are registered from the next state so pins track the FSM.
    always_ff @(posedge MemClk or negedge ResetN) begin
        if (!ResetN) begin
            MemAddr     <= '0;
            MemDataOut  <= '0;
            MemDataOe   <= 1'b0;
            MemWE       <= 1'b1;
            MemOE       <= 1'b1;
            RdData      <= '0;
            RdDataValid <= 1'b0;
            sc          <= '0;
        end else begin
            MemOE       <= (state_nx != READ);
            MemWE       <= (state_nx != WRITE_PULSE);
            MemDataOe   <= (state_nx inside {WRITE_SETUP, WRITE_PULSE,
                                             WRITE_HOLD});
            RdDataValid <= rd_last;
            if (rd_last) begin
                RdData <= MemDataIn;
            end
            if (rd_grant) begin
                MemAddr <= RdAddr;
            end
            if (wr_grant) begin
                MemAddr    <= WrAddr;
                MemDataOut <= WrData;
            end
            if (!WrReq || wr_grant) begin
                sc <= '0;
            end else if (rd_grant && sc != 4'hF) begin
                sc <= sc + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vmem_arb.sv
// Scoreboard bench for vmem_arb: directed requests push expectations,
// a negedge monitor pops and compares against the DUT pins.
module tb_vmem_arb;
    import vga_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         lat;
    } rd_exp_t;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
        int          gap;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        rd_dv;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic [18:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_doe;
    logic [7:0]  mem_din = 8'hFF;
    logic        mem_we;
    logic        mem_oe;
    logic        busy;

    logic        f_rd_req = 1'b0;
    logic [18:0] f_rd_addr = 19'h00123;
    logic        f_rd_ack;
    logic [7:0]  f_rd_data;
    logic        f_rd_dv;
    logic        f_wr_ack;
    logic [18:0] f_mem_addr;
    logic [7:0]  f_mem_dout;
    logic        f_mem_doe;
    logic [7:0]  f_mem_din = 8'hFF;
    logic        f_mem_we;
    logic        f_mem_oe;
    logic        f_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    op_t     grant_q[$];
    int      rd_ack_cyc[$];
    int      wr_ack_cyc[$];

    logic [7:0] mem [logic [18:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vmem_arb #(
        .AWIDTH(DEF_AWIDTH), .DWIDTH(DEF_DWIDTH),
        .RDCYCLES(DEF_RDCYCLES), .WRCYCLES(DEF_WRCYCLES),
        .TURNCYCLES(DEF_TURNCYCLES), .WRSTARVE(DEF_WRSTARVE)
    ) u_dut (
        .MemClk(clk), .ResetN(rst_n),
        .RdReq(rd_req), .RdAddr(rd_addr), .RdAck(rd_ack),
        .RdData(rd_data), .RdDataValid(rd_dv),
        .WrReq(wr_req), .WrAddr(wr_addr), .WrData(wr_data),
        .WrAck(wr_ack),
        .MemAddr(mem_addr), .MemDataOut(mem_dout),
        .MemDataOe(mem_doe), .MemDataIn(mem_din),
        .MemWE(mem_we), .MemOE(mem_oe), .Busy(busy)
    );

    vmem_arb #(
        .RDCYCLES(1), .TURNCYCLES(0)
    ) u_fast (
        .MemClk(clk), .ResetN(rst_n),
        .RdReq(f_rd_req), .RdAddr(f_rd_addr), .RdAck(f_rd_ack),
        .RdData(f_rd_data), .RdDataValid(f_rd_dv),
        .WrReq(1'b0), .WrAddr(19'h0), .WrData(8'h0),
        .WrAck(f_wr_ack),
        .MemAddr(f_mem_addr), .MemDataOut(f_mem_dout),
        .MemDataOe(f_mem_doe), .MemDataIn(f_mem_din),
        .MemWE(f_mem_we), .MemOE(f_mem_oe), .Busy(f_busy)
    );

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // SRAM models: write while WE low, drive read data while OE low.
    always @(negedge clk) begin
        if (!mem_we) mem[mem_addr] = mem_dout;
        if (!mem_oe && mem.exists(mem_addr)) mem_din = mem[mem_addr];
        else mem_din = 8'hFF;
        f_mem_din = f_mem_oe ? 8'hFF : (f_mem_addr[7:0] ^ 8'h3C);
    end

    int oe_run = 0;
    int we_run = 0;
    logic prev_doe = 1'b0;

    always @(negedge clk) begin
        op_t     g;
        rd_exp_t r;
        wr_exp_t w;
        int      a;
        if (!rst_n) begin
            rd_ack_cyc.delete();
            wr_ack_cyc.delete();
            oe_run = 0;
            we_run = 0;
            prev_doe = 1'b0;
        end else begin
            chk("we_oe_overlap", longint'(!mem_we && !mem_oe), 0);
            chk("doe_oe_overlap", longint'(mem_doe && !mem_oe), 0);
            if (rd_ack && wr_ack) chk("dual_ack", 1, 0);
            if (rd_ack || wr_ack) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_order", longint'(wr_ack),
                        longint'(g == OP_WRITE));
                end
                if (rd_ack) rd_ack_cyc.push_back(cyc);
                if (wr_ack) wr_ack_cyc.push_back(cyc);
            end
            if (!mem_oe) oe_run++;
            else if (oe_run != 0) begin
                chk("oe_width", oe_run, 2);
                oe_run = 0;
            end
            if (!mem_we) we_run++;
            else if (we_run != 0) begin
                chk("we_width", we_run, 2);
                we_run = 0;
            end
            if (mem_doe && !prev_doe) begin
                if (wr_q.size() == 0 || wr_ack_cyc.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    a = wr_ack_cyc.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_dout, w.data);
                    chk("wr_gap", cyc - a, w.gap);
                end
            end
            if (rd_dv) begin
                if (rd_q.size() == 0 || rd_ack_cyc.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    a = rd_ack_cyc.pop_front();
                    chk("rd_data", rd_data, r.data);
                    chk("rd_latency", cyc - a, r.lat);
                end
            end
            prev_doe = mem_doe;
        end
    end

    int f_acks = 0;
    int f_dvs = 0;
    int f_last_ack = -1;
    int f_last_dv = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (f_rd_ack) begin
                if (f_last_ack >= 0) chk("fast_ack_gap", cyc - f_last_ack, 3);
                f_last_ack = cyc;
                f_acks++;
            end
            if (f_rd_dv) begin
                chk("fast_data", f_rd_data, 8'h1F);
                chk("fast_latency", cyc - f_last_ack, 2);
                if (f_last_dv >= 0) chk("fast_dv_gap", cyc - f_last_dv, 3);
                f_last_dv = cyc;
                f_dvs++;
            end
        end
    end

    task automatic exp_rd(input logic [7:0] d, input int lat);
        grant_q.push_back(OP_READ);
        rd_q.push_back('{data: d, lat: lat});
    endtask

    task automatic exp_wr(input logic [18:0] a, input logic [7:0] d,
                          input int gap);
        grant_q.push_back(OP_WRITE);
        wr_q.push_back('{addr: a, data: d, gap: gap});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input logic [18:0] a);
        int n = 0;
        rd_addr = a;
        rd_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_ack && n < 50);
        if (!rd_ack) chk("rd_ack_timeout", 0, 1);
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic issue_wr(input logic [18:0] a, input logic [7:0] d);
        int n = 0;
        wr_addr = a;
        wr_data = d;
        wr_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_ack && n < 50);
        if (!wr_ack) chk("wr_ack_timeout", 0, 1);
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mem[19'h00010] = 8'hA5;
        mem[19'h00300] = 8'h77;

        rd_req = 1'b1;
        wr_req = 1'b1;
        idle(2);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_we", mem_we, 1);
        chk("rst_oe", mem_oe, 1);
        chk("rst_doe", mem_doe, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dout", mem_dout, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_dv", rd_dv, 0);
        chk("rst_busy", busy, 0);
        rd_req = 1'b0;
        wr_req = 1'b0;
        rst_n = 1'b1;
        idle(2);

        exp_rd(8'hA5, 3);
        issue_rd(19'h00010);
        idle(6);

        exp_wr(19'h7FFFF, 8'h5C, 2);
        issue_wr(19'h7FFFF, 8'h5C);
        idle(8);
        chk("model_7ffff", mem[19'h7FFFF], 8'h5C);
        exp_rd(8'h5C, 4);
        issue_rd(19'h7FFFF);
        idle(6);

        exp_wr(19'h00200, 8'h11, 2);
        issue_wr(19'h00200, 8'h11);
        idle(8);
        exp_rd(8'h11, 4);
        issue_rd(19'h00200);
        idle(6);
        exp_wr(19'h00200, 8'h22, 2);
        issue_wr(19'h00200, 8'h22);
        idle(8);
        exp_rd(8'h22, 4);
        issue_rd(19'h00200);
        idle(6);

        repeat (4) exp_rd(8'h77, 3);
        exp_wr(19'h00400, 8'h99, 2);
        exp_rd(8'h77, 4);
        repeat (3) exp_rd(8'h77, 3);
        exp_wr(19'h00400, 8'h99, 2);
        rd_addr = 19'h00300;
        wr_addr = 19'h00400;
        wr_data = 8'h99;
        rd_req = 1'b1;
        wr_req = 1'b1;
        n = 0;
        while (grant_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        chk("starve_pending_grants", grant_q.size(), 0);
        idle(10);

        exp_wr(19'h00500, 8'h33, 1);
        issue_wr(19'h00500, 8'h33);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_we && n < 10);
        chk("reach_write_pulse", mem_we, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_we", mem_we, 1);
        chk("async_rst_doe", mem_doe, 0);
        chk("async_rst_oe", mem_oe, 1);
        chk("async_rst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        chk("post_rst_busy", busy, 0);
        exp_rd(8'hA5, 3);
        issue_rd(19'h00010);
        idle(6);

        f_rd_req = 1'b1;
        n = 0;
        while (f_acks < 6 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 f_rd_req = 1'b0;
        idle(8);
        chk("fast_acks", f_acks, 6);
        chk("fast_dvs", f_dvs, 6);

        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("grant_q_empty", grant_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
